// File: rtl/pitch_quiz_ctrl.sv
// pitch_quiz_ctrl -- sequencer for one ear-training round.
//
// A round plays a reference tone on the octave synthesizer, waits through a
// short silence, then hands the synthesizer back to the user keyboard and
// waits for the first fresh key press (or a timeout). The result is reported
// as a one-cycle pulse and the score/round counters are updated.
//
// Optional feature: define QUIZ_REPLAY_EN to let the user request the tone
// once more while listening. Without it, replay is ignored and res_replayed
// is tied to 0.
//
// Ports
//   CLK100MHZ      in   sole clock, rising edge
//   CPU_RESETN     in   synchronous reset, active low
//   tgt_valid      in   round request
//   tgt_ready      out  controller can accept a round (IDLE only)
//   tgt_note       in   [3:0] target note, 1..12 = C..B
//   tgt_octave     in   [2:0] target octave
//   played_octid   in   [3:0] key from the user keyboard path, 0 = none
//   replay         in   request to hear the tone again
//   abort          in   cancel the current round
//   ctrl_keys      out  [11:0] one-hot key drive to the synthesizer
//   ctrl_octave    out  [2:0] octave drive to the synthesizer
//   ctrl_play_en   out  synthesizer play enable
//   ctrl_owns      out  1 = controller drives synthesizer, 0 = keyboard does
//   res_valid      out  one-cycle result pulse
//   res_correct    out  answered note matched the target
//   res_timeout    out  no press before the listen window expired
//   res_error      out  request carried an invalid note id
//   res_replayed   out  the tone was replayed during the round
//   res_note       out  [3:0] captured answer (0 on timeout/error)
//   score          out  [7:0] correct answers, saturating
//   rounds         out  [7:0] completed rounds, saturating
//   busy           out  round in progress
//   dbg_state_o    out  [2:0] current FSM state
//
// Handshake: a request transfers on a rising edge where tgt_valid and
// tgt_ready are both 1; tgt_note/tgt_octave are latched on that edge. Ready
// does not depend on valid, and valid may be held high across cycles.

module pitch_quiz_ctrl #(
    parameter int unsigned TONE_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [3:0]  tgt_note,
    input  logic [2:0]  tgt_octave,
    input  logic [3:0]  played_octid,
    input  logic        replay,
    input  logic        abort,
    output logic [11:0] ctrl_keys,
    output logic [2:0]  ctrl_octave,
    output logic        ctrl_play_en,
    output logic        ctrl_owns,
    output logic        res_valid,
    output logic        res_correct,
    output logic        res_timeout,
    output logic        res_error,
    output logic        res_replayed,
    output logic [3:0]  res_note,
    output logic [7:0]  score,
    output logic [7:0]  rounds,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TONE   = 3'd1,
        S_GAP    = 3'd2,
        S_LISTEN = 3'd3,
        S_JUDGE  = 3'd4
    } state_t;

    localparam logic [31:0] TONE_LAST    = TONE_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LAST     = GAP_CYCLES - 32'd1;
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [3:0]  note_q;
    logic        seen_zero_q;
    logic        tgt_ready_q;
    logic        busy_q;
    logic [11:0] ctrl_keys_q;
    logic [2:0]  ctrl_octave_q;
    logic        ctrl_play_en_q;
    logic        ctrl_owns_q;
    logic        res_valid_q;
    logic        res_correct_q;
    logic        res_timeout_q;
    logic        res_error_q;
    logic [3:0]  res_note_q;
    logic [7:0]  score_q;
    logic [7:0]  rounds_q;
`ifdef QUIZ_REPLAY_EN
    logic        replayed_q;
    logic        res_replayed_q;
`endif

    logic note_ok;
    logic press;

    function automatic logic [11:0] note_to_key(input logic [3:0] n);
        note_to_key = 12'd1 << (n - 4'd1);
    endfunction

    assign note_ok = (tgt_note >= 4'd1) && (tgt_note <= 4'd12);

    // Only an edge from "no key" to "key" seen inside LISTEN counts, so a key
    // held down from before the window opened can never answer.
    assign press = (state_q == S_LISTEN) && (played_octid != 4'd0) && seen_zero_q;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q        <= S_IDLE;
            cnt_q          <= 32'd0;
            note_q         <= 4'd0;
            seen_zero_q    <= 1'b0;
            tgt_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            ctrl_keys_q    <= 12'd0;
            ctrl_octave_q  <= 3'd0;
            ctrl_play_en_q <= 1'b0;
            ctrl_owns_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            res_correct_q  <= 1'b0;
            res_timeout_q  <= 1'b0;
            res_error_q    <= 1'b0;
            res_note_q     <= 4'd0;
            score_q        <= 8'd0;
            rounds_q       <= 8'd0;
`ifdef QUIZ_REPLAY_EN
            replayed_q     <= 1'b0;
            res_replayed_q <= 1'b0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tgt_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (tgt_valid && tgt_ready_q) begin
                        if (note_ok) begin
                            state_q        <= S_TONE;
                            cnt_q          <= 32'd0;
                            note_q         <= tgt_note;
                            tgt_ready_q    <= 1'b0;
                            busy_q         <= 1'b1;
                            ctrl_keys_q    <= note_to_key(tgt_note);
                            ctrl_octave_q  <= tgt_octave;
                            ctrl_play_en_q <= 1'b1;
                            ctrl_owns_q    <= 1'b1;
`ifdef QUIZ_REPLAY_EN
                            replayed_q     <= 1'b0;
`endif
                        end else begin
                            // Bad note: report immediately, no round is played.
                            res_valid_q    <= 1'b1;
                            res_error_q    <= 1'b1;
                            res_correct_q  <= 1'b0;
                            res_timeout_q  <= 1'b0;
                            res_note_q     <= 4'd0;
`ifdef QUIZ_REPLAY_EN
                            res_replayed_q <= 1'b0;
`endif
                        end
                    end
                end

                S_TONE, S_GAP, S_LISTEN: begin
                    if (abort) begin
                        state_q        <= S_IDLE;
                        tgt_ready_q    <= 1'b1;
                        busy_q         <= 1'b0;
                        ctrl_keys_q    <= 12'd0;
                        ctrl_octave_q  <= 3'd0;
                        ctrl_play_en_q <= 1'b0;
                        ctrl_owns_q    <= 1'b0;
                    end else if (state_q == S_TONE) begin
                        if (cnt_q == TONE_LAST) begin
                            state_q        <= S_GAP;
                            cnt_q          <= 32'd0;
                            ctrl_keys_q    <= 12'd0;
                            ctrl_play_en_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end else if (state_q == S_GAP) begin
                        if (cnt_q == GAP_LAST) begin
                            state_q     <= S_LISTEN;
                            cnt_q       <= 32'd0;
                            ctrl_owns_q <= 1'b0;
                            seen_zero_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end else if (press) begin
                        // A press beats both replay and expiry on the same cycle.
                        state_q        <= S_JUDGE;
                        res_valid_q    <= 1'b1;
                        res_note_q     <= played_octid;
                        res_correct_q  <= (played_octid == note_q);
                        res_timeout_q  <= 1'b0;
                        res_error_q    <= 1'b0;
`ifdef QUIZ_REPLAY_EN
                        res_replayed_q <= replayed_q;
                    end else if (replay && !replayed_q) begin
                        state_q        <= S_TONE;
                        cnt_q          <= 32'd0;
                        replayed_q     <= 1'b1;
                        ctrl_keys_q    <= note_to_key(note_q);
                        ctrl_play_en_q <= 1'b1;
                        ctrl_owns_q    <= 1'b1;
`endif
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q        <= S_JUDGE;
                        res_valid_q    <= 1'b1;
                        res_note_q     <= 4'd0;
                        res_correct_q  <= 1'b0;
                        res_timeout_q  <= 1'b1;
                        res_error_q    <= 1'b0;
`ifdef QUIZ_REPLAY_EN
                        res_replayed_q <= replayed_q;
`endif
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        if (played_octid == 4'd0) begin
                            seen_zero_q <= 1'b1;
                        end
                    end
                end

                S_JUDGE: begin
                    state_q       <= S_IDLE;
                    tgt_ready_q   <= 1'b1;
                    busy_q        <= 1'b0;
                    ctrl_octave_q <= 3'd0;
                    if (rounds_q != 8'hFF) begin
                        rounds_q <= rounds_q + 8'd1;
                    end
                    if (res_correct_q && (score_q != 8'hFF)) begin
                        score_q <= score_q + 8'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef QUIZ_REPLAY_EN
    assign res_replayed = res_replayed_q;
`else
    logic unused_replay;
    assign unused_replay = replay;
    assign res_replayed  = 1'b0;
`endif

    assign tgt_ready    = tgt_ready_q;
    assign busy         = busy_q;
    assign ctrl_keys    = ctrl_keys_q;
    assign ctrl_octave  = ctrl_octave_q;
    assign ctrl_play_en = ctrl_play_en_q;
    assign ctrl_owns    = ctrl_owns_q;
    assign res_valid    = res_valid_q;
    assign res_correct  = res_correct_q;
    assign res_timeout  = res_timeout_q;
    assign res_error    = res_error_q;
    assign res_note     = res_note_q;
    assign score        = score_q;
    assign rounds       = rounds_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pitch_quiz_ctrl.sv
module tb_pitch_quiz_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tgt_valid = 1'b0;
  logic        tgt_ready;
  logic [3:0]  tgt_note = 4'd0;
  logic [2:0]  tgt_octave = 3'd0;
  logic [3:0]  played_octid = 4'd0;
  logic        replay = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] ctrl_keys;
  logic [2:0]  ctrl_octave;
  logic        ctrl_play_en;
  logic        ctrl_owns;
  logic        res_valid;
  logic        res_correct;
  logic        res_timeout;
  logic        res_error;
  logic        res_replayed;
  logic [3:0]  res_note;
  logic [7:0]  score;
  logic [7:0]  rounds;
  logic        busy;
  logic [2:0]  dbg_state;

`ifdef QUIZ_REPLAY_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  pitch_quiz_ctrl #(
    .TONE_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_note(tgt_note),
    .tgt_octave(tgt_octave),
    .played_octid(played_octid),
    .replay(replay),
    .abort(abort),
    .ctrl_keys(ctrl_keys),
    .ctrl_octave(ctrl_octave),
    .ctrl_play_en(ctrl_play_en),
    .ctrl_owns(ctrl_owns),
    .res_valid(res_valid),
    .res_correct(res_correct),
    .res_timeout(res_timeout),
    .res_error(res_error),
    .res_replayed(res_replayed),
    .res_note(res_note),
    .score(score),
    .rounds(rounds),
    .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int exp_score = 0;
  int exp_rounds = 0;
  // {error, correct, timeout, replayed, note}
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] model_result(input logic [3:0] note, input logic [3:0] press,
                                              input bit hold, input bit rep);
    if (note == 4'd0 || note > 4'd12) return {1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    if (press != 4'd0 && !hold) return {1'b0, (press == note), 1'b0, rep, press};
    return {1'b0, 1'b0, 1'b1, rep, 4'h0};
  endfunction

  task automatic model_count(input logic [3:0] note, input logic [3:0] press, input bit hold);
    if (note >= 4'd1 && note <= 4'd12) begin
      if (exp_rounds < 255) exp_rounds++;
      if (!hold && press == note && exp_score < 255) exp_score++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_res_valid", 32'(res_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("result", 32'({res_error, res_correct, res_timeout, res_replayed, res_note}),
                 32'(mon_exp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // Starts at a negedge in IDLE; returns one negedge after the result pulse.
  task automatic do_round(input logic [3:0] note, input logic [2:0] oct,
                          input logic [3:0] press, input int press_at, input bit hold);
    int lat;
    int exp_lat;
    bit seen;
    bit ok;
    logic [11:0] key;
    ok = (note >= 4'd1 && note <= 4'd12);
    key = ok ? (12'd1 << (note - 4'd1)) : 12'd0;
    if (!ok) exp_lat = 1;
    else if (press != 4'd0 && !hold) exp_lat = 8 + press_at;
    else exp_lat = 17;
    check_eq("ready_idle", 32'(tgt_ready), 32'd1);
    tgt_valid = 1'b1;
    tgt_note = note;
    tgt_octave = oct;
    if (hold) played_octid = press;
    exp_q.push_back(model_result(note, press, hold, 1'b0));
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      tgt_valid = 1'b0;
      if (res_valid) seen = 1'b1;
      if (!ok && lat == 1) check_eq("err_no_tone", 32'({busy, ctrl_play_en}), 32'd0);
      if (ok && lat >= 1 && lat <= 4) begin
        check_eq("tone_keys", 32'(ctrl_keys), 32'(key));
        check_eq("tone_play_owns", 32'({ctrl_play_en, ctrl_owns, busy}), 32'b111);
        check_eq("tone_octave", 32'(ctrl_octave), 32'(oct));
      end
      if (ok && (lat == 5 || lat == 6)) begin
        check_eq("gap_keys", 32'(ctrl_keys), 32'd0);
        check_eq("gap_play_owns", 32'({ctrl_play_en, ctrl_owns}), 32'b01);
        check_eq("gap_octave", 32'(ctrl_octave), 32'(oct));
      end
      if (ok && lat == 7)
        check_eq("listen_outputs", 32'({ctrl_keys, ctrl_play_en, ctrl_owns}), 32'd0);
      if (ok && !hold && press != 4'd0 && lat == 7 + press_at) played_octid = press;
    end
    check_eq("res_latency", lat, exp_lat);
    played_octid = 4'd0;
    model_count(note, press, hold);
    @(negedge clk);
    check_eq("score", 32'(score), exp_score);
    check_eq("rounds", 32'(rounds), exp_rounds);
    check_eq("idle_busy", 32'({busy, tgt_ready}), 32'b01);
  endtask

  task automatic do_abort(input logic [3:0] note, input int at_lat);
    tgt_valid = 1'b1;
    tgt_note = note;
    tgt_octave = 3'd6;
    for (int i = 1; i <= at_lat; i++) begin
      @(negedge clk);
      tgt_valid = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_idle", 32'({busy, tgt_ready}), 32'b01);
    check_eq("abort_ctrl", 32'({ctrl_keys, ctrl_octave, ctrl_play_en, ctrl_owns}), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("abort_score", 32'(score), exp_score);
    check_eq("abort_rounds", 32'(rounds), exp_rounds);
  endtask

  task automatic do_replay_round();
    int lat;
    int exp_lat;
    int press_lat;
    bit seen;
    exp_lat = REP_EN ? 20 : 12;
    press_lat = exp_lat - 1;
    tgt_valid = 1'b1;
    tgt_note = 4'd5;
    tgt_octave = 3'd3;
    exp_q.push_back(model_result(4'd5, 4'd5, 1'b0, REP_EN));
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      tgt_valid = 1'b0;
      if (res_valid) seen = 1'b1;
      replay = (lat == 9 || lat == 17);
      if (lat == 10) begin
        if (REP_EN) check_eq("replay_tone", 32'({ctrl_keys, ctrl_play_en, ctrl_owns}),
                             32'({12'h010, 2'b11}));
        else check_eq("replay_ignored", 32'({ctrl_keys, ctrl_play_en, ctrl_owns}), 32'd0);
      end
      if (REP_EN && lat == 14) check_eq("replay_gap", 32'({ctrl_play_en, ctrl_owns}), 32'b01);
      if (lat == press_lat) played_octid = 4'd5;
    end
    replay = 1'b0;
    check_eq("replay_latency", lat, exp_lat);
    played_octid = 4'd0;
    model_count(4'd5, 4'd5, 1'b0);
    @(negedge clk);
    check_eq("replay_score", 32'(score), exp_score);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(tgt_ready), 32'd0);
    check_eq("rst_outputs", 32'({busy, res_valid, res_correct, res_timeout, res_error,
                                 res_replayed, res_note}), 32'd0);
    check_eq("rst_ctrl", 32'({ctrl_keys, ctrl_octave, ctrl_play_en, ctrl_owns}), 32'd0);
    check_eq("rst_counters", 32'({score, rounds}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(tgt_ready), 32'd1);

    do_round(4'd5, 3'd3, 4'd5, 1, 1'b0);   // correct answer
    do_round(4'd7, 3'd2, 4'd8, 3, 1'b0);   // wrong answer
    do_round(4'd9, 3'd1, 4'd0, 0, 1'b0);   // no press -> timeout
    do_round(4'd2, 3'd4, 4'd2, 0, 1'b1);   // key held into LISTEN -> timeout
    do_round(4'd0, 3'd0, 4'd1, 1, 1'b0);   // invalid notes
    do_round(4'd13, 3'd0, 4'd1, 1, 1'b0);
    do_round(4'd15, 3'd0, 4'd1, 1, 1'b0);
    do_round(4'd12, 3'd7, 4'd12, 9, 1'b0); // press on the expiry cycle wins
    do_round(4'd1, 3'd0, 4'd1, 2, 1'b0);

    do_abort(4'd3, 2);                     // abort on TONE cycle 2
    do_abort(4'd4, 5);                     // abort in GAP
    do_abort(4'd6, 9);                     // abort in LISTEN

    do_replay_round();

    // Drive score and rounds into saturation, then one more correct round.
    while (exp_score < 255) begin
      logic [3:0] n;
      n = 4'($urandom_range(1, 12));
      do_round(n, 3'($urandom_range(0, 7)), n, $urandom_range(1, 6), 1'b0);
    end
    do_round(4'd11, 3'd2, 4'd11, 1, 1'b0);
    check_eq("score_sat", 32'(score), 32'd255);
    check_eq("rounds_sat", 32'(rounds), 32'd255);

    // Reset in the middle of a round discards it.
    tgt_valid = 1'b1;
    tgt_note = 4'd6;
    tgt_octave = 3'd5;
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_score = 0;
    exp_rounds = 0;
    check_eq("midrst_outputs", 32'({tgt_ready, busy, ctrl_owns, ctrl_octave, res_valid}), 32'd0);
    check_eq("midrst_counters", 32'({score, rounds}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(tgt_ready), 32'd1);
    do_round(4'd10, 3'd6, 4'd10, 1, 1'b0);

    repeat (5) @(negedge clk);
    check_eq("leftover_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pitch_quiz_ctrl.md
PITCH_QUIZ_CTRL -- requirements
Module: pitch_quiz_ctrl

Interface
REQ-001 SHALL have parameter TONE_CYCLES, default 50_000_000, reference-tone duration in clocks.
REQ-002 SHALL have parameter GAP_CYCLES, default 10_000_000, silence between tone and listen window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500_000_000, listen-window length; all counters 32 bits.
REQ-004 CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-005 CPU_RESETN  in  1  synchronous reset, active-low.
REQ-006 tgt_valid / tgt_ready  in / out  1 / 1  round-request handshake.
REQ-007 tgt_note  in  4  target note id, 1..12 = C..B.
REQ-008 tgt_octave  in  3  target octave number.
REQ-009 played_octid  in  4  user note id from keyboard path, 0 = no key.
REQ-010 replay  in  1  request to hear the tone again.
REQ-011 abort  in  1  cancel current round.
REQ-012 ctrl_keys / ctrl_octave / ctrl_play_en  out  12 / 3 / 1  drive to the octave synthesizer.
REQ-013 ctrl_owns  out  1  1 = controller drives synthesizer, 0 = user keyboard drives it.
REQ-014 res_valid  out  1  one-cycle result pulse; res_correct, res_timeout, res_error, res_replayed out 1 each; res_note out 4 captured note.
REQ-015 score / rounds  out  8 / 8  correct-answer and completed-round counts; busy out 1.

Function
REQ-016 States: IDLE, TONE, GAP, LISTEN, JUDGE; busy = 1 in every state except IDLE.
REQ-017 tgt_ready = 1 only in IDLE; a request is accepted on a cycle with tgt_valid & tgt_ready, latching tgt_note and tgt_octave.
REQ-018 Accepted tgt_note of 0 or 13..15: stay IDLE, next cycle res_valid pulse with res_error=1, res_correct=0; score and rounds unchanged.
REQ-019 Valid accept -> TONE the next cycle: ctrl_keys one-hot at bit (tgt_note-1), ctrl_play_en=1, ctrl_owns=1, exactly TONE_CYCLES cycles.
REQ-020 GAP: ctrl_keys=0, ctrl_play_en=0, ctrl_owns=1, exactly GAP_CYCLES cycles; ctrl_octave holds the latched octave throughout the round.
REQ-021 LISTEN: ctrl_owns=0, ctrl_keys=0, ctrl_play_en=0; counts up to TIMEOUT_CYCLES.
REQ-022 In LISTEN, a press is a cycle where played_octid is nonzero and played_octid was 0 on a prior LISTEN cycle; a key held since before LISTEN never counts.
REQ-023 On a press, capture played_octid into res_note and go to JUDGE; on counter expiry go to JUDGE with res_timeout=1, res_note=0.
REQ-024 Press and timeout on the same cycle: the press wins, res_timeout=0.
REQ-025 JUDGE lasts one cycle: res_valid=1, res_correct = (res_note == latched note), then IDLE; result fields hold until the next res_valid.
REQ-026 In JUDGE, rounds increments and score increments if res_correct; both saturate at 255.
REQ-027 abort in TONE/GAP/LISTEN: IDLE the next cycle, ctrl_* cleared, ctrl_owns=0, no res_valid, counters unchanged; abort in IDLE or JUDGE is ignored.

Reset
REQ-028 While CPU_RESETN=0 on a clock edge: state IDLE, all outputs 0 including tgt_ready, score and rounds; tgt_ready=1 on the first cycle after release.
REQ-029 Reset asserted mid-round discards the round with no res_valid.

Configuration
REQ-030 Macro QUIZ_REPLAY_EN defined: the first replay=1 cycle in LISTEN returns to TONE with the listen counter cleared, and res_replayed=1 in that round's result; later replays in the round are ignored; a press on the same cycle wins over replay.
REQ-031 Macro QUIZ_REPLAY_EN undefined: replay is ignored and res_replayed is tied 0.

Verification (TONE_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=10)
REQ-032 Accept note 5, octave 3 -> ctrl_keys=12'h010 with play_en=1 for 4 cycles; 2 silent cycles; ctrl_owns=0; press 5 -> res_valid, res_correct=1, score=1, rounds=1.
REQ-033 Note 7 with press 8 -> res_correct=0, res_note=8, score unchanged, rounds+1.
REQ-034 No press -> res_timeout=1 exactly 10 cycles into LISTEN; key held into LISTEN and never released -> timeout.
REQ-035 Accept note 0 -> res_error=1 the next cycle, no TONE, rounds unchanged; note 13 -> same.
REQ-036 abort on TONE cycle 2 -> IDLE the next cycle, ctrl_keys=0, no res_valid; score=255 plus a correct round -> score stays 255.
REQ-037 With QUIZ_REPLAY_EN: replay in LISTEN -> 4 TONE cycles again, second replay ignored, result res_replayed=1; without QUIZ_REPLAY_EN -> replay has no effect.
